// File: rtl/tone_pkg.sv
// Shared types and constants for the tone decoder: FSM states, period bin
// boundaries (in 100 kHz clock cycles) and the note-to-7-segment table.
package tone_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_ACQUIRE = 2'd2,
    ST_LOCKED  = 2'd3
  } tone_state_e;

  // Accepted period range in cycles.
  localparam int unsigned P_MIN = 180;
  localparam int unsigned P_MAX = 400;

  // Lower period bound of each note bin, longest period (lowest note) first.
  localparam int unsigned BIN_0 = 361;
  localparam int unsigned BIN_1 = 321;
  localparam int unsigned BIN_2 = 294;
  localparam int unsigned BIN_3 = 270;
  localparam int unsigned BIN_4 = 241;
  localparam int unsigned BIN_5 = 214;
  localparam int unsigned BIN_6 = 196;

  localparam logic [3:0] NOTE_NONE = 4'd15;
  localparam logic [7:0] LED_OFF   = 8'h00;
  localparam logic [7:0] LED_DASH  = 8'h40;

  // Segments a..g on bits 0..6, dp on bit 7 (dp marks the upper C).
  localparam logic [7:0] NOTE_SEG [8] = '{
    8'h39, 8'h5E, 8'h79, 8'h71, 8'h3D, 8'h77, 8'h7C, 8'hB9
  };

  function automatic logic in_range(input logic [31:0] p);
    return (p >= P_MIN) && (p <= P_MAX);
  endfunction

  function automatic logic [2:0] note_bin(input logic [31:0] p);
    if (p >= BIN_0) return 3'd0;
    if (p >= BIN_1) return 3'd1;
    if (p >= BIN_2) return 3'd2;
    if (p >= BIN_3) return 3'd3;
    if (p >= BIN_4) return 3'd4;
    if (p >= BIN_5) return 3'd5;
    if (p >= BIN_6) return 3'd6;
    return 3'd7;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
// Usable for any slow asynchronous input (tone lines, buttons).
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic s1, s2, s3;

  // Synchronize, delay one more stage, and register the rise detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= din;
      s2    <= s1;
      s3    <= s2;
      pulse <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/tone_decoder.sv
// Measures the period of a square-wave tone, classifies it into one of
// eight notes (C4..C5) once it has been stable for LOCK_COUNT periods, and
// shows the note on a 7-segment bus. Silence drops back to IDLE.
module tone_decoder
  import tone_pkg::*;
#(
  parameter int CNT_W      = 20,
  parameter int LOCK_COUNT = 4,
  parameter int TOL_SHIFT  = 4,
  parameter int SILENCE_MS = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      ticks_per_milli,
  input  logic             tone_in,
  output logic [3:0]       note,
  output logic             note_valid,
  output logic             note_strobe,
  output logic [CNT_W-1:0] period,
  output logic [7:0]       led,
  output tone_state_e      dbg_state
);

  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam int MS_W = $clog2(SILENCE_MS + 1);

  logic              tone_edge;
  logic [CNT_W-1:0]  cnt;
  logic [15:0]       tick_cnt, tpm_q, tpm_eff;
  logic [MS_W-1:0]   ms_cnt;
  logic              tick_wrap, silence, measure;
  logic [31:0]       p32, prev32;
  logic              p_in_range, consistent;
  logic [2:0]        p_bin, prev_bin;
  logic [CNT_W-1:0]  diff, tol;
  tone_state_e       state, state_nxt;
  logic [MC_W-1:0]   match_cnt, mc_nxt;
  logic [3:0]        note_d;
  logic [7:0]        led_d;
  logic              valid_d, strobe_d;

  edge_sync u_edge_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (tone_in),
    .pulse (tone_edge)
  );

  assign dbg_state = state;

  // Candidate period is the running counter value at the edge; compare
  // it with the previously measured period.
  always_comb begin
    tpm_eff    = (ticks_per_milli == 16'd0) ? 16'd1 : ticks_per_milli;
    tick_wrap  = (tick_cnt == tpm_q - 16'd1);
    silence    = tick_wrap && (ms_cnt == MS_W'(SILENCE_MS - 1));
    measure    = tone_edge && !silence && (state != ST_IDLE);
    p32        = 32'(cnt);
    prev32     = 32'(period);
    p_in_range = in_range(p32);
    p_bin      = note_bin(p32);
    prev_bin   = note_bin(prev32);
    diff       = (cnt > period) ? (cnt - period) : (period - cnt);
    tol        = period >> TOL_SHIFT;
    consistent = p_in_range && (diff <= tol) && (p_bin == prev_bin);
  end

  // Period counter restarts at 1 on every edge and saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      period <= '0;
    end else begin
      if (tone_edge)      cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
      else if (cnt != '1) cnt <= cnt + 1'b1;
      if (measure) period <= cnt;
    end
  end

  // Silence timer; the ms length is re-latched at each ms boundary so a
  // ticks_per_milli change only affects the following millisecond.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      ms_cnt   <= '0;
      tpm_q    <= tpm_eff;
    end else if (tone_edge) begin
      tick_cnt <= '0;
      ms_cnt   <= '0;
      tpm_q    <= tpm_eff;
    end else if (tick_wrap) begin
      tick_cnt <= '0;
      tpm_q    <= tpm_eff;
      if (ms_cnt != MS_W'(SILENCE_MS)) ms_cnt <= ms_cnt + 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      match_cnt <= '0;
    end else begin
      state     <= state_nxt;
      match_cnt <= mc_nxt;
    end
  end

  // Next-state logic; silence overrides an edge in the same cycle.
  always_comb begin
    state_nxt = state;
    mc_nxt    = match_cnt;
    if (silence) begin
      state_nxt = ST_IDLE;
      mc_nxt    = '0;
    end else if (tone_edge) begin
      case (state)
        ST_IDLE: state_nxt = ST_ARMED;
        ST_ARMED: begin
          if (p_in_range) begin
            state_nxt = ST_ACQUIRE;
            mc_nxt    = MC_W'(1);
          end
        end
        ST_ACQUIRE: begin
          if (!p_in_range) begin
            state_nxt = ST_ARMED;
            mc_nxt    = '0;
          end else if (consistent) begin
            mc_nxt = match_cnt + 1'b1;
          end else begin
            mc_nxt = MC_W'(1);
          end
        end
        ST_LOCKED: begin
          if (!consistent) begin
            if (p_in_range) begin
              state_nxt = ST_ACQUIRE;
              mc_nxt    = MC_W'(1);
            end else begin
              state_nxt = ST_ARMED;
              mc_nxt    = '0;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
      if (state_nxt == ST_ACQUIRE && mc_nxt == MC_W'(LOCK_COUNT))
        state_nxt = ST_LOCKED;
    end
  end

  // Output values for the upcoming state; registered below.
  always_comb begin
    note_d   = NOTE_NONE;
    valid_d  = (state_nxt == ST_LOCKED);
    strobe_d = (state_nxt == ST_LOCKED) && (state != ST_LOCKED);
    if (state_nxt == ST_LOCKED)
      note_d = (state == ST_LOCKED) ? note : {1'b0, p_bin};
    case (state_nxt)
      ST_IDLE:   led_d = LED_OFF;
      ST_LOCKED: led_d = NOTE_SEG[note_d[2:0]];
      default:   led_d = LED_DASH;
    endcase
  end

  // Output register: everything updates together one cycle after the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      note        <= NOTE_NONE;
      note_valid  <= 1'b0;
      note_strobe <= 1'b0;
      led         <= LED_OFF;
    end else begin
      note        <= note_d;
      note_valid  <= valid_d;
      note_strobe <= strobe_d;
      led         <= led_d;
    end
  end

endmodule

// File: tb/tb_tone_decoder.sv
// Testbench for tone_decoder: drives tone periods rise by rise and checks
// every post-edge output update against a note-level reference model.
module tb_tone_decoder;
  import tone_pkg::*;

  localparam int CNT_W = 20;
  localparam int EXP_W = 34;  // {note4, valid1, strobe1, led8, period20}

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [15:0]      ticks_per_milli = 16'd100;
  logic             tone_in = 1'b0;
  logic [3:0]       note;
  logic             note_valid, note_strobe;
  logic [CNT_W-1:0] period;
  logic [7:0]       led;
  tone_state_e      dbg_state;

  tone_decoder #(.CNT_W(CNT_W), .LOCK_COUNT(4), .TOL_SHIFT(4), .SILENCE_MS(50)) dut (
    .clk             (clk),
    .rst             (rst),
    .ticks_per_milli (ticks_per_milli),
    .tone_in         (tone_in),
    .note            (note),
    .note_valid      (note_valid),
    .note_strobe     (note_strobe),
    .period          (period),
    .led             (led),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int strobe_cnt = 0;
  int prev_len = 0;

  always @(negedge clk) if (note_strobe === 1'b1) strobe_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  tone_state_e m_state;
  int m_cnt, m_note, m_period;
  bit m_strobe;
  int  bin_lo [7] = '{361, 321, 294, 270, 241, 214, 196};
  logic [7:0] seg_tab [8] = '{8'h39, 8'h5E, 8'h79, 8'h71, 8'h3D, 8'h77, 8'h7C, 8'hB9};
  logic [EXP_W-1:0] exp_q [$];

  function automatic int ref_bin(input int p);
    for (int i = 0; i < 7; i++) if (p >= bin_lo[i]) return i;
    return 7;
  endfunction

  function automatic bit ref_inr(input int p);
    return (p >= 180) && (p <= 400);
  endfunction

  function automatic bit ref_cons(input int p, input int prev);
    int d;
    d = (p > prev) ? p - prev : prev - p;
    return ref_inr(p) && (d <= (prev >> 4)) && (ref_bin(p) == ref_bin(prev));
  endfunction

  function automatic logic [7:0] ref_led();
    if (m_state == ST_IDLE) return 8'h00;
    if (m_state == ST_LOCKED) return seg_tab[m_note];
    return 8'h40;
  endfunction

  task automatic model_reset();
    m_state = ST_IDLE; m_cnt = 0; m_note = 15; m_period = 0; m_strobe = 0;
  endtask

  // One rising edge with measured period p (ignored when idle).
  task automatic model_rise(input int p);
    logic [EXP_W-1:0] e;
    bit was_locked;
    was_locked = (m_state == ST_LOCKED);
    if (m_state == ST_IDLE) begin
      m_state = ST_ARMED;
    end else begin
      bit cons, inr;
      cons = ref_cons(p, m_period);
      inr  = ref_inr(p);
      if (m_state == ST_ARMED) begin
        if (inr) begin m_state = ST_ACQUIRE; m_cnt = 1; end
      end else if (m_state == ST_ACQUIRE) begin
        if (!inr) begin m_state = ST_ARMED; m_cnt = 0; end
        else m_cnt = cons ? m_cnt + 1 : 1;
      end else if (!cons) begin
        m_state = inr ? ST_ACQUIRE : ST_ARMED;
        m_cnt   = inr ? 1 : 0;
      end
      if (m_state == ST_ACQUIRE && m_cnt == 4) m_state = ST_LOCKED;
      m_period = p;
    end
    m_strobe = (m_state == ST_LOCKED) && !was_locked;
    if (m_state != ST_LOCKED) m_note = 15;
    else if (!was_locked) m_note = ref_bin(m_period);
    e = {4'(m_note), (m_state == ST_LOCKED), m_strobe, ref_led(), 20'(m_period)};
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic [15:0] tpm);
    @(negedge clk);
    rst = 1'b1; tone_in = 1'b0; ticks_per_milli = tpm;
    repeat (3) @(negedge clk);
    check("rst_note", 32'(note), 32'd15);
    check("rst_led", 32'(led), 32'h00);
    check("rst_valid", 32'(note_valid), 32'd0);
    check("rst_period", 32'(period), 32'd0);
    rst = 1'b0;
    model_reset();
    prev_len = 0;
    @(negedge clk);
  endtask

  task automatic compare_rise(input string tag);
    logic [EXP_W-1:0] e;
    e = exp_q.pop_front();
    check({tag, "_note"}, 32'(note), 32'(e[33:30]));
    check({tag, "_valid"}, 32'(note_valid), 32'(e[29]));
    check({tag, "_strobe"}, 32'(note_strobe), 32'(e[28]));
    check({tag, "_led"}, 32'(led), 32'(e[27:20]));
    check({tag, "_period"}, 32'(period), 32'(e[19:0]));
    check({tag, "_state"}, 32'(dbg_state), 32'(m_state));
  endtask

  // Rise now, check the post-edge update 4 clocks later, finish a cycle of len.
  task automatic rise(input int len, input string tag);
    tone_in = 1'b1;
    model_rise(prev_len);
    repeat (4) @(negedge clk);
    compare_rise(tag);
    repeat (len / 2 - 4) @(negedge clk);
    tone_in = 1'b0;
    repeat (len - len / 2) @(negedge clk);
    prev_len = len;
  endtask

  // Final rise then silence: still active 2 cycles before the deadline,
  // idle one cycle after it.
  task automatic silence_check(input int n_cyc, input string tag);
    tone_in = 1'b1;
    model_rise(prev_len);
    repeat (4) @(negedge clk);
    compare_rise(tag);
    tone_in = 1'b0;
    repeat (n_cyc - 2) @(negedge clk);
    check({tag, "_pre_state"}, 32'(dbg_state), 32'(m_state));
    repeat (3) @(negedge clk);
    m_state = ST_IDLE; m_note = 15;
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    check({tag, "_led"}, 32'(led), 32'h00);
    check({tag, "_note"}, 32'(note), 32'd15);
    check({tag, "_valid"}, 32'(note_valid), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s0, cur, nxt, r;

    // A4 lock from silence
    do_reset(16'd100);
    s0 = strobe_cnt;
    for (int i = 0; i < 6; i++) rise(227, "a4");
    check("a4_strobe_once", 32'(strobe_cnt - s0), 32'd1);
    check("a4_note_const", 32'(note), 32'd5);
    check("a4_led_const", 32'(led), 32'h77);
    check("a4_period_const", 32'(period), 32'd227);

    // jitter within tolerance keeps the lock
    s0 = strobe_cnt;
    cur = 227;
    for (int i = 0; i < 20; i++) begin
      nxt = cur + int'($urandom_range(0, 20)) - 10;
      if (nxt < 217) nxt = 217;
      if (nxt > 237) nxt = 237;
      rise(nxt, "jit");
      cur = nxt;
    end
    check("jit_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    check("jit_valid", 32'(note_valid), 32'd1);

    // switch to C4
    for (int i = 0; i < 2; i++) rise(382, "sw");
    check("sw_drop_note", 32'(note), 32'd15);
    check("sw_drop_led", 32'(led), 32'h40);
    for (int i = 0; i < 4; i++) rise(382, "sw");
    check("sw_relock_note", 32'(note), 32'd0);
    check("sw_relock_led", 32'(led), 32'h39);

    // randomized period mix
    do_reset(16'($urandom_range(40, 200)));
    cur = 227;
    for (int i = 0; i < 50; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5) nxt = cur;
      else if (r < 8) nxt = cur + int'($urandom_range(0, 10)) - 5;
      else nxt = int'($urandom_range(150, 450));
      if (nxt < 150) nxt = 150;
      if (nxt > 450) nxt = 450;
      rise(nxt, "rnd");
      cur = nxt;
    end

    // out-of-range tone never arms past ARMED
    do_reset(16'd100);
    for (int i = 0; i < 6; i++) rise(1000, "slow");
    check("slow_valid", 32'(note_valid), 32'd0);
    check("slow_period", 32'(period), 32'd1000);
    check("slow_state", 32'(dbg_state), 32'(ST_ARMED));

    // silence after lock, 50 ms at 100 ticks/ms
    do_reset(16'd100);
    for (int i = 0; i < 5; i++) rise(227, "pre_sil");
    silence_check(5000, "sil");

    // ticks_per_milli = 0 behaves as 1
    do_reset(16'd0);
    silence_check(50, "sil0");

    // reset while locked
    do_reset(16'd100);
    for (int i = 0; i < 5; i++) rise(227, "pre_rst");
    check("pre_rst_valid", 32'(note_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_note", 32'(note), 32'd15);
    check("mid_rst_valid", 32'(note_valid), 32'd0);
    check("mid_rst_strobe", 32'(note_strobe), 32'd0);
    check("mid_rst_led", 32'(led), 32'h00);
    check("mid_rst_period", 32'(period), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_decoder.md
# tone_decoder

Measures the period of an incoming square-wave tone, such as the speaker line driven by `music_processor`, and decodes it into one of eight notes (C4..C5). It shows the decoded note on the 7-segment LED bus. The block is the listening end of the speaker interface: a loopback or second tile can verify playback without a scope. It assumes the standard 100 kHz tile clock; all period constants are in clock cycles at that rate.

## Interface
Parameters:
- `CNT_W`, 20: period counter width; the counter saturates at all-ones.
- `LOCK_COUNT`, 4: number of consecutive consistent periods required to lock.
- `TOL_SHIFT`, 4: allowed period deviation is `prev_period >> TOL_SHIFT`.
- `SILENCE_MS`, 50: milliseconds without a rising edge before the block declares silence.

Ports:
- `clk`, in, 1: system clock, single clock domain.
- `rst`, in, 1: reset, synchronous and active-high.
- `ticks_per_milli`, in, 16: clock cycles per millisecond; a value of 0 is treated as 1.
- `tone_in`, in, 1: asynchronous square-wave input.
- `note`, out, 4: decoded note index 0..7 (C4, D4, E4, F4, G4, A4, B4, C5); 15 when no note is decoded.
- `note_valid`, out, 1: high while in LOCKED.
- `note_strobe`, out, 1: one-cycle pulse on entry to LOCKED.
- `period`, out, CNT_W: last measured period in cycles.
- `led`, out, 8: 7-segment pattern; segments a..g on bits 0..6, dp on bit 7.

## Operation
- Input conditioning:
  - `tone_in` passes through a 2-flop synchronizer, then a registered rising-edge detector that produces `edge`.
  - A period counter increments every cycle and saturates.
  - On `edge`: `period` is loaded with the counter value and the counter restarts at 1.
- Classification, per measured period p (boundaries held in the package):
  - In range only if 180 ≤ p ≤ 400; otherwise "out of range".
  - Bins: p ≥ 361 → 0, ≥ 321 → 1, ≥ 294 → 2, ≥ 270 → 3, ≥ 241 → 4, ≥ 214 → 5, ≥ 196 → 6, else → 7.
- Consistent period: p is in range, |p − prev| ≤ prev >> TOL_SHIFT, and bin(p) = bin(prev).
- FSM states: IDLE, ARMED, ACQUIRE, LOCKED.
  - IDLE: the first `edge` moves to ARMED and clears the counter. No period is produced.
  - ARMED: the next `edge` produces the first period. If p is in range, go to ACQUIRE with `match_cnt` = 1; otherwise stay in ARMED.
  - ACQUIRE: on each `edge`:
    - consistent period → `match_cnt`++;
    - in range but not consistent → `match_cnt` = 1;
    - out of range → ARMED.
    - When `match_cnt` reaches LOCK_COUNT: go to LOCKED, latch `note` = bin, pulse `note_strobe`.
  - LOCKED: a consistent `edge` keeps the lock. Any inconsistent or out-of-range period → ACQUIRE (`match_cnt` = 1 if in range, else ARMED), and `note` returns to 15.
- Silence timer:
  - A tick counter counts to `ticks_per_milli`; a ms counter counts milliseconds.
  - Both clear on every `edge`.
  - When the ms counter reaches SILENCE_MS, go to IDLE from any state and clear `match_cnt`.
  - Silence has priority over an `edge` arriving in the same cycle.
- LED patterns:
  - IDLE: 0x00.
  - ARMED / ACQUIRE: 0x40 (dash).
  - LOCKED, by note: C 0x39, d 0x5E, E 0x79, F 0x71, G 0x3D, A 0x77, b 0x7C, C5 0xB9.
- Reset state: all outputs registered; `note` = 15, `note_valid` = 0, `note_strobe` = 0, `period` = 0, `led` = 0x00. State = IDLE, all counters 0.
- Reset mid-operation: abandons the lock immediately, with no strobe.

## Timing
- `tone_in` rise → `edge`: 3 cycles.
- `edge` → updated `period`, FSM state, `note`, `note_valid` and `led`: 1 cycle, all visible together.
- `note_strobe` is high for exactly one cycle, aligned with `note_valid` first going high.
- Lock latency from silence: 1 (arm) + LOCK_COUNT edges. At 440 Hz with LOCK_COUNT = 4 this is 5 rising edges.
- Silence is declared exactly SILENCE_MS × `ticks_per_milli` cycles after the last `edge`, ±1 cycle.
- A `ticks_per_milli` change takes effect at the next ms boundary.

## Structure
- Package `tone_pkg` holds:
  - the state enum;
  - bin boundary constants (361, 321, 294, 270, 241, 214, 196) and range limits (180, 400);
  - the note-to-segment constant array;
  - NOTE_NONE = 15.
- Sub-module `edge_sync` contains the 2-flop synchronizer plus the registered rising-edge pulse. It is reusable for button inputs.
- Period measurement, classification, FSM and silence timer live in the top module.

## Test plan
- Reset held 3 cycles, `tone_in` = 0 → `note` = 15, `led` = 0x00, `note_valid` = 0, `period` = 0.
- 440 Hz square wave (period 227, `ticks_per_milli` = 100) → `note_strobe` once on the 5th edge, `note` = 5, `led` = 0x77, `period` = 227.
- Locked on A4, then ±10-cycle jitter per period (tolerance 14) → lock held, no further strobe.
- Locked on A4, switch to period 382 → `note` = 15, `led` = 0x40, then relock after 4 periods with `note` = 0, `led` = 0x39.
- Period 1000 (100 Hz) indefinitely → never leaves ARMED, `note_valid` = 0, `period` = 1000.
- Locked, then `tone_in` held low → IDLE exactly 5000 cycles after the last edge, `led` = 0x00. Separately, assert `rst` while LOCKED → all outputs return to reset values on the next clock.
